// File: rtl/led_pkg.sv
// Shared constants and types for the RGB PWM fader.
// Holds default widths, channel indices and the per-channel fade state.
package led_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int FADE_DIV_DEF = 23438;

    localparam int NUM_CH = 3;
    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } fade_state_e;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Per-channel bus between the shared timebase and one pwm_channel.
// master: drives tick/cnt/target, reads lvl/busy/pwm; slave: the reverse.
interface rgb_pwm_fader_if #(
    parameter int W = 8
);

    logic         tick;
    logic [W-1:0] cnt;
    logic [W-1:0] target;
    logic [W-1:0] lvl;
    logic         busy;
    logic         pwm;

    modport master (
        output tick, cnt, target,
        input  lvl, busy, pwm
    );

    modport slave (
        input  tick, cnt, target,
        output lvl, busy, pwm
    );

endinterface

// File: rtl/rgb_pwm_fader_channel.sv
// One fading PWM channel: level register, HOLD/RISE/FALL state, compare.
// Ports: clk, rst (sync, active-high), bus (slave side of the channel bus).
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    rgb_pwm_fader_if.slave   bus
);

    fade_state_e         state;
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] lvl_nxt;
    logic                pwm_q;

    // State follows the live target, so a mid-fade change redirects on the
    // very next tick. Unit steps land exactly on target: no overshoot/wrap.
    always_comb begin
        state   = ST_HOLD;
        lvl_nxt = lvl;
        if (lvl < bus.target) begin
            state = ST_RISE;
        end else if (lvl > bus.target) begin
            state = ST_FALL;
        end
        if (bus.tick) begin
            unique case (state)
                ST_RISE: lvl_nxt = lvl + 1'b1;
                ST_FALL: lvl_nxt = lvl - 1'b1;
                default: lvl_nxt = lvl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl   <= '0;
            pwm_q <= ACTIVE_LOW;
        end else begin
            lvl   <= lvl_nxt;
            pwm_q <= (bus.cnt < lvl) ^ ACTIVE_LOW;
        end
    end

    assign bus.lvl  = lvl;
    assign bus.busy = (state != ST_HOLD);
    assign bus.pwm  = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: three PWM channels that ramp toward on/off targets.
// Ports: CLK_IN, RST, LED_REQ[2:0], BRIGHT, RGB_LED[2:0], FADE_BUSY.
module rgb_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int FADE_DIV   = FADE_DIV_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                CLK_IN,
    input  logic                RST,
    input  logic [2:0]          LED_REQ,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic [2:0]          RGB_LED,
    output logic                FADE_BUSY
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    pre;
    logic                fade_tick;
    logic [NUM_CH-1:0]   busy_vec;
    logic [NUM_CH-1:0]   pwm_vec;

    // Shared timebase; the tick is high in the cycle the prescaler reads 0
    // after a wrap, so the first tick lands FADE_DIV cycles after reset.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            pwm_cnt   <= '0;
            pre       <= '0;
            fade_tick <= 1'b0;
            FADE_BUSY <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            fade_tick <= (pre == DIV_MAX);
            pre       <= (pre == DIV_MAX) ? '0 : pre + 1'b1;
            FADE_BUSY <= |busy_vec;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgb_pwm_fader_if #(.W(PWM_BITS)) ch_if ();

        assign ch_if.tick   = fade_tick;
        assign ch_if.cnt    = pwm_cnt;
        assign ch_if.target = LED_REQ[i] ? BRIGHT : '0;

        pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk(CLK_IN),
            .rst(RST),
            .bus(ch_if)
        );

        assign busy_vec[i] = ch_if.busy;
        assign pwm_vec[i]  = ch_if.pwm;
    end

    assign RGB_LED = pwm_vec;

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: PWM counter and level width.
REQ-002 SHALL have parameter FADE_DIV, default 23438: CLK_IN cycles per fade tick (~0.25 s full ramp at 24 MHz).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts RGB_LED at the output register.
REQ-004 SHALL have port CLK_IN, input, 1: sole clock, 24 MHz.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port LED_REQ, input, 3: per-channel on/off request, driven by the colour sequencer; bit0=R, bit1=G, bit2=B.
REQ-007 SHALL have port BRIGHT, input, PWM_BITS: full-on level for every requested channel.
REQ-008 SHALL have port RGB_LED, output, 3: PWM drive to the pins.
REQ-009 SHALL have port FADE_BUSY, output, 1: high while any channel level differs from its target.

Function
REQ-010 SHALL run a free-running PWM_BITS counter PWM_CNT that increments every cycle and wraps from 2^PWM_BITS-1 to 0.
REQ-011 SHALL run a prescaler counting 0..FADE_DIV-1 and pulse FADE_TICK for one cycle when it wraps to 0.
REQ-012 SHALL compute each channel's target every cycle as LED_REQ[i] ? BRIGHT : 0.
REQ-013 SHALL give each channel a level register LVL[i] and a state: HOLD (LVL==target), RISE (LVL<target), FALL (LVL>target).
REQ-014 SHALL, on FADE_TICK only, step LVL by +1 in RISE and by -1 in FALL, and leave it unchanged in HOLD.
REQ-015 SHALL never let a step overshoot: LVL reaches target exactly, with no wrap below 0 or above 2^PWM_BITS-1.
REQ-016 SHALL register channel output as (PWM_CNT < LVL[i]), giving one cycle of latency from PWM_CNT/LVL to RGB_LED, then apply ACTIVE_LOW.
REQ-017 SHALL use these duty boundaries: LVL=0 gives a constantly inactive channel; LVL=2^PWM_BITS-1 gives inactive exactly one count per PWM period.
REQ-018 SHALL redirect an in-progress fade on the next FADE_TICK when LED_REQ or BRIGHT changes mid-fade, with no restart from 0.
REQ-019 SHALL use the target sampled in the cycle of FADE_TICK when a request change coincides with that tick.
REQ-020 SHALL register FADE_BUSY as the OR over channels of (LVL[i] != target[i]), with 1 cycle of latency.

Reset
REQ-021 SHALL, while RST=1 at a CLK_IN edge, set PWM_CNT=0, prescaler=0, all LVL=0 and FADE_BUSY=0, and drive RGB_LED inactive (3'b000, or 3'b111 if ACTIVE_LOW).
REQ-022 SHALL let a mid-fade reset abandon the fade; after release, channels ramp from 0 toward current targets.
REQ-023 SHALL treat RST as overriding all other activity in the same cycle.

Structure
REQ-024 SHALL place PWM_BITS default, FADE_DIV default and channel index constants (CH_R=0, CH_G=1, CH_B=2) in shared package led_pkg.
REQ-025 SHALL implement per-channel LVL, state and compare in sub-module pwm_channel, instantiated three times.
REQ-026 SHALL keep PWM_CNT and the prescaler in the top level, shared by all channels.

Verification
REQ-027 SHALL cover basic ramp: FADE_DIV=4, BRIGHT=8'hFF, LED_REQ 000->001 -> LVL[R] reaches 255 after 255 ticks (1020 cycles); G and B stay 0; FADE_BUSY falls 1 cycle later.
REQ-028 SHALL cover duty: LVL=64 held -> RGB_LED[0] high for exactly 64 of each 256 cycles; LVL=0 -> never high.
REQ-029 SHALL cover redirect: ramp R up, switch LED_REQ to 000 at LVL=100 -> LVL goes 100, 99, ... 0 in 100 ticks, with no step to 0 or 255.
REQ-030 SHALL cover brightness drop: BRIGHT 200->50 while LVL=200 -> 150 falling ticks, then HOLD at 50.
REQ-031 SHALL cover reset: assert RST for 1 cycle at LVL=128 -> next cycle all LVL=0, RGB_LED=000, FADE_BUSY=0; with ACTIVE_LOW=1, RGB_LED=111.
REQ-032 SHALL cover the rotating sequence: LED_REQ 001->010->100 every 1000 cycles -> outgoing channel falls while incoming rises concurrently, with FADE_BUSY high during each crossfade.
